// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: frame FSM states,
// prefix byte values and the set of keyboard control codes that never map to keys.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  // Acks, self-test results, echo and error replies from the keyboard.
  function automatic logic ps2_is_ctrl(input logic [7:0] code);
    case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: ps2_is_ctrl = 1'b1;
      default:                                                ps2_is_ctrl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter: the output follows the
// pin only after FILTER_LEN consecutive equal samples. Idles (and resets) high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    cnt_d  = '0;
    dout_d = dout_q;
    if (sync_q[1] != dout_q) begin
      // cnt_q counts differing samples already seen; this one completes the run.
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        dout_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      dout_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: filters the pins, deframes 11-bit frames on filtered
// clock falls and folds E0/F0/E1 prefixes into an 11-bit toggle-style key event.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 3600
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err_parity,
  output logic        err_frame
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_f, data_f;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk (clk_sys),
    .rst (reset),
    .din (ps2_clk),
    .dout(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk (clk_sys),
    .rst (reset),
    .din (ps2_data),
    .dout(data_f)
  );

  ps2_state_e    state_q, state_d;
  logic          clk_prev_q, clk_prev_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;
  logic          err_par_q, err_par_d;
  logic          err_frm_q, err_frm_d;

  logic bit_ev;
  logic timeout;

  assign bit_ev  = clk_prev_q & ~clk_f;
  assign timeout = (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC));

  always_comb begin
    state_d    = state_q;
    clk_prev_d = clk_f;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    to_cnt_d   = to_cnt_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    skip_d     = skip_q;
    key_d      = key_q;
    err_par_d  = 1'b0;
    err_frm_d  = 1'b0;

    if (bit_ev || state_q == ST_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TW'(TIMEOUT_CYC)) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    // A bit event outranks the timeout, so a stop bit landing on the limit still counts.
    if (bit_ev) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_f) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shreg_d   = {data_f, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_f;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!data_f) begin
            err_frm_d = 1'b1;
            ext_d = 1'b0; brk_d = 1'b0; skip_d = 3'd0;
          end else if (!(^{shreg_q, par_q})) begin
            err_par_d = 1'b1;
            ext_d = 1'b0; brk_d = 1'b0; skip_d = 3'd0;
          end else if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
          end else if (shreg_q == PS2_EXT) begin
            ext_d = 1'b1;
          end else if (shreg_q == PS2_BRK) begin
            brk_d = 1'b1;
          end else if (shreg_q == PS2_PAUSE) begin
            skip_d = PS2_PAUSE_SKIP;
          end else if (ps2_is_ctrl(shreg_q)) begin
            ext_d = 1'b0; brk_d = 1'b0;
          end else begin
            key_d = {~key_q[10], ~brk_q, ext_q, shreg_q};
            ext_d = 1'b0; brk_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d   = ST_IDLE;
      err_frm_d = 1'b1;
      ext_d = 1'b0; brk_d = 1'b0; skip_d = 3'd0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= 3'd0;
      key_q      <= 11'h000;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_prev_q <= clk_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      key_q      <= key_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
    end
  end

  assign ps2_key    = key_q;
  assign err_parity = err_par_q;
  assign err_frame  = err_frm_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames on the raw pins, queues the key
// events it expects and compares them with the ps2_key changes a monitor records.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 3600;
  localparam int HALF        = 40;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        err_parity;
  logic        err_frame;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .err_parity(err_parity),
    .err_frame (err_frame)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic [10:0] prev_key = 11'h000;
  logic        tog      = 1'b0;

  int par_pulses = 0, frm_pulses = 0;
  int par_run = 0, frm_run = 0, par_max = 0, frm_max = 0;

  // Records every ps2_key change and measures error pulse counts and widths.
  always @(negedge clk_sys) begin
    if (ps2_key !== prev_key) begin
      obs_q.push_back(ps2_key);
      prev_key = ps2_key;
    end
    if (err_parity === 1'b1) par_run++;
    else begin
      if (par_run != 0) begin
        par_pulses++;
        if (par_run > par_max) par_max = par_run;
      end
      par_run = 0;
    end
    if (err_frame === 1'b1) frm_run++;
    else begin
      if (frm_run != 0) begin
        frm_pulses++;
        if (frm_run > frm_max) frm_max = frm_run;
      end
      frm_run = 0;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par, input logic stop,
                            input int gap);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
    wait_clks(gap);
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_frame(code, ~^code, 1'b1, 4 * HALF);
  endtask

  task automatic expect_event(input logic pressed, input logic ext, input logic [7:0] code);
    tog = ~tog;
    exp_q.push_back({tog, pressed, ext, code});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_clks(5);
    checks++;
    if (ps2_key !== 11'h000) begin
      failures++; $display("FAIL reset_key: got %h want 000", ps2_key);
    end
    checks++;
    if (err_parity !== 1'b0 || err_frame !== 1'b0) begin
      failures++; $display("FAIL reset_err: got par=%b frm=%b want 0 0", err_parity, err_frame);
    end
    reset = 1'b0;
    wait_clks(20);
  endtask

  task automatic test_single_latency;
    int  lat;
    int  p0, f0;
    logic [10:0] e, o;
    p0 = par_pulses; f0 = frm_pulses;
    lat = -1;
    expect_event(1'b1, 1'b0, 8'h29);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h29 >> i));
    send_bit(~^8'h29);
    ps2_data = 1'b1;
    wait_clks(HALF);
    @(posedge clk_sys); #1;
    ps2_clk = 1'b0;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(posedge clk_sys); @(negedge clk_sys);
      if (ps2_key !== 11'h000) lat = i;
    end
    wait_clks(HALF);
    ps2_clk = 1'b1;
    wait_clks(4 * HALF);
    checks++;
    if (lat != FILTER_LEN + 3) begin
      failures++; $display("FAIL stop_latency: got %0d cycles want %0d", lat, FILTER_LEN + 3);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL single_event: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL single_event: got %h want %h", o, e); end
      end
    end
    checks++;
    if (par_pulses != p0 || frm_pulses != f0) begin
      failures++; $display("FAIL single_err: got par=%0d frm=%0d want 0 0", par_pulses - p0, frm_pulses - f0);
    end
  endtask

  task automatic test_ext_release;
    logic [10:0] e, o;
    send_byte(8'hE0);
    send_byte(8'hF0);
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL prefix_only: got %0d events want 0", obs_q.size());
    end
    expect_event(1'b0, 1'b1, 8'h75);
    send_byte(8'h75);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL ext_release: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL ext_release: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_parity;
    int p0;
    logic [10:0] e, o;
    p0 = par_pulses;
    send_frame(8'h1C, ^8'h1C, 1'b1, 4 * HALF);
    checks++;
    if (par_pulses - p0 != 1 || par_max != 1) begin
      failures++; $display("FAIL parity_pulse: got count=%0d width=%0d want 1 1", par_pulses - p0, par_max);
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL parity_drop: got %0d events want 0", obs_q.size());
    end
    expect_event(1'b1, 1'b0, 8'h1C);
    send_byte(8'h1C);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL parity_recover: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL parity_recover: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_frame_errors;
    int f0;
    logic [10:0] e, o;
    f0 = frm_pulses;
    for (int i = 0; i < 5; i++) send_bit(1'(5'b01010 >> i));
    ps2_data = 1'b1;
    wait_clks(TIMEOUT_CYC + 200);
    checks++;
    if (frm_pulses - f0 != 1 || frm_max != 1) begin
      failures++; $display("FAIL timeout_pulse: got count=%0d width=%0d want 1 1", frm_pulses - f0, frm_max);
    end
    send_frame(8'h33, ~^8'h33, 1'b0, 4 * HALF);
    checks++;
    if (frm_pulses - f0 != 2) begin
      failures++; $display("FAIL stop_bit_pulse: got count=%0d want 2", frm_pulses - f0);
    end
    expect_event(1'b1, 1'b0, 8'h05);
    send_byte(8'h05);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL frame_recover: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL frame_recover: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_glitch_ctrl;
    int p0, f0;
    logic [10:0] e, o;
    p0 = par_pulses; f0 = frm_pulses;
    ps2_data = 1'b0;
    wait_clks(5);
    ps2_clk = 1'b0;
    wait_clks(7);
    ps2_clk = 1'b1;
    wait_clks(20);
    ps2_data = 1'b1;
    wait_clks(4 * HALF);
    send_byte(8'hFA);
    send_byte(8'hAA);
    expect_event(1'b1, 1'b0, 8'h1D);
    send_byte(8'h1D);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL glitch_ctrl: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL glitch_ctrl: got %h want %h", o, e); end
      end
    end
    checks++;
    if (par_pulses != p0 || frm_pulses != f0) begin
      failures++; $display("FAIL glitch_err: got par=%0d frm=%0d want 0 0", par_pulses - p0, frm_pulses - f0);
    end
  endtask

  task automatic test_pause;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [10:0] e, o;
    foreach (seq[i]) send_byte(seq[i]);
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL pause_swallow: got %0d events want 0", obs_q.size());
    end
    expect_event(1'b1, 1'b0, 8'h16);
    send_byte(8'h16);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL pause_next: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL pause_next: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] e, o;
    expect_event(1'b1, 1'b0, 8'h1B);
    expect_event(1'b1, 1'b0, 8'h23);
    expect_event(1'b0, 1'b0, 8'h1B);
    send_frame(8'h1B, ~^8'h1B, 1'b1, 0);
    send_frame(8'h23, ~^8'h23, 1'b1, 0);
    send_frame(8'hF0, ~^8'hF0, 1'b1, 0);
    send_frame(8'h1B, ~^8'h1B, 1'b1, 4 * HALF);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL back_to_back: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL back_to_back: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [10:0] e, o;
    send_byte(8'hE0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_clks(10);
    exp_q.push_back(11'h000);
    tog = 1'b0;
    reset = 1'b1;
    wait_clks(3);
    checks++;
    if (ps2_key !== 11'h000 || err_parity !== 1'b0 || err_frame !== 1'b0) begin
      failures++; $display("FAIL midframe_reset: got key=%h par=%b frm=%b want 000 0 0", ps2_key, err_parity, err_frame);
    end
    reset = 1'b0;
    wait_clks(4 * HALF);
    expect_event(1'b1, 1'b0, 8'h1A);
    send_byte(8'h1A);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL reset_recover: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL reset_recover: got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL extra_events: got %0d unexpected events want 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_ext_release();
    test_parity();
    test_frame_errors();
    test_glitch_ctrl();
    test_pause();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
